// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state
// encoding, framing constants and a small mid-bit helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Framing: 8 data bits, no parity, 1 stop bit.
    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int BIT_IDX_W   = $clog2(DATA_BITS);
    localparam int DIV_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Counter value at which the start bit is re-checked: the middle of
    // the start bit, so every later sample lands mid-bit.
    function automatic logic [DIV_W-1:0] half_period(input logic [DIV_W-1:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/axi_fifo.sv
// ---------------------------------------------------------------------------
// axi_fifo
// Synchronous stream FIFO, 2**SIZE entries of WIDTH bits.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_tdata/i_tvalid      write side data / valid
//   i_tready              write side ready (high when not full)
//   o_tdata/o_tvalid      read side data (oldest entry) / valid (not empty)
//   o_tready              read side ready (pop request)
//   o_level               number of occupied entries (0..2**SIZE)
//
// Handshake: a beat transfers on a cycle where valid and ready are both
// high. Valid never depends on ready. A write while full and a read while
// empty are therefore no-ops. Simultaneous push and pop both happen.
// ---------------------------------------------------------------------------
module axi_fifo #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [SIZE:0]    o_level
);

    localparam int DEPTH = 1 << SIZE;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SIZE-1:0]  r_wr_ptr;
    logic [SIZE-1:0]  r_rd_ptr;
    logic [SIZE:0]    r_level;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_level == (SIZE+1)'(DEPTH));
    assign w_push   = i_tvalid && !w_full;
    assign w_pop    = o_tready && (r_level != '0);

    assign i_tready = !w_full;
    assign o_tvalid = (r_level != '0);
    assign o_tdata  = r_mem[r_rd_ptr];
    assign o_level  = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_tdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// 8N1 UART receiver with a 2**SIZE-entry receive FIFO.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clkdiv[15:0]  bit period minus one, in clk cycles (3..65535)
//   rx            asynchronous serial input, idle high, LSB first
//   fifo_out      oldest received byte
//   fifo_read     pop one byte (ignored when empty)
//   fifo_level    occupied FIFO entries
//   fifo_empty    high when fifo_level == 0
//   frame_err     one-cycle pulse on a low stop bit
//   overrun       one-cycle pulse when a good byte is dropped (FIFO full)
//   dbg_state     current receiver FSM state (rx_state_t encoding)
// ---------------------------------------------------------------------------
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int SIZE = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             rx,
    output logic [7:0]       fifo_out,
    input  logic             fifo_read,
    output logic [SIZE:0]    fifo_level,
    output logic             fifo_empty,
    output logic             frame_err,
    output logic             overrun,
    output logic [2:0]       dbg_state
);

    rx_state_t                r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic [DIV_W-1:0]         r_div_q;
    logic [DIV_W-1:0]         r_baud_ctr;
    logic [BIT_IDX_W-1:0]     r_bit_ctr;
    logic [DATA_BITS-1:0]     r_shreg;
    logic                     r_frame_err;
    logic                     r_overrun;

    logic                     w_rxs;
    logic                     w_baud_done;
    logic                     w_push;
    logic                     w_fifo_ready;
    logic                     w_fifo_valid;

    // Synchronizer: rx enters at bit 0, the synchronized value leaves the
    // top bit. Reset to 1 so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rxs       = r_sync[SYNC_STAGES-1];
    assign w_baud_done = (r_baud_ctr == r_div_q);

    // The byte is offered to the FIFO on the stop-sample cycle itself;
    // the FIFO drops it when full and the FSM flags the overrun.
    assign w_push = (r_state == ST_STOP) && w_baud_done && w_rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_div_q     <= '0;
            r_baud_ctr  <= '0;
            r_bit_ctr   <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // clkdiv is captured here only, so mid-frame changes
                    // wait for the next start bit.
                    if (!w_rxs) begin
                        r_div_q    <= clkdiv;
                        r_baud_ctr <= '0;
                        r_bit_ctr  <= '0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_baud_ctr == half_period(r_div_q)) begin
                        r_baud_ctr <= '0;
                        r_state    <= w_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        r_baud_ctr <= r_baud_ctr + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_shreg[r_bit_ctr] <= w_rxs;
                        r_baud_ctr         <= '0;
                        r_bit_ctr          <= r_bit_ctr + 1'b1;
                        if (r_bit_ctr == BIT_IDX_W'(DATA_BITS-1)) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_baud_ctr <= r_baud_ctr + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud_ctr <= '0;
                        if (w_rxs) begin
                            r_overrun <= !w_fifo_ready;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_baud_ctr <= r_baud_ctr + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) must not restart reception.
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axi_fifo #(
        .WIDTH (8),
        .SIZE  (SIZE)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_tdata  (r_shreg),
        .i_tvalid (w_push),
        .i_tready (w_fifo_ready),
        .o_tdata  (fifo_out),
        .o_tvalid (w_fifo_valid),
        .o_tready (fifo_read),
        .o_level  (fifo_level)
    );

    assign fifo_empty = ~w_fifo_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;
    import uart_pkg::*;

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] clkdiv = 16'd15;
    logic        rx = 1'b1;
    logic        fifo_read = 1'b0;
    logic [7:0]  fifo_out;
    logic [5:0]  fifo_level;
    logic        fifo_empty;
    logic        frame_err;
    logic        overrun;
    logic [2:0]  dbg_state;

    uart_rx_deframer #(.SIZE(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clkdiv     (clkdiv),
        .rx         (rx),
        .fifo_out   (fifo_out),
        .fifo_read  (fifo_read),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int max_level = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_err) fe_cnt += 1;
        if (overrun)   ov_cnt += 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: all called on a falling edge, return on a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input int per);
        rx = b;
        repeat (per) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int per);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(d[i], per);
        drive_bit(stop_bit, per);
        rx = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check(tag, 32'(fifo_out), 32'(e));
        fifo_read = 1'b1;
        @(negedge clk);
        fifo_read = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_ovr",   32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Clean frame 0xA5 at clkdiv=15 (first frame after reset)
        send_frame(8'hA5, 1'b1, 16);
        idle(4);
        check("a5_level", 32'(fifo_level), 32'd1);
        check("a5_empty", 32'(fifo_empty), 32'd0);
        check("a5_ferr",  32'(fe_cnt), 32'd0);
        check("a5_ovr",   32'(ov_cnt), 32'd0);
        exp_q.push_back(8'hA5);
        pop_check("a5_data");
        check("a5_pop_empty", 32'(fifo_empty), 32'd1);

        // Start glitch: 4 low cycles
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
        check("glitch_empty", 32'(fifo_empty), 32'd1);
        check("glitch_ferr",  32'(fe_cnt), 32'd0);

        // Read while empty is ignored
        fifo_read = 1'b1;
        idle(1);
        fifo_read = 1'b0;
        check("rd_empty_level", 32'(fifo_level), 32'd0);

        // Frame 0x3C with low stop bit, line held low 100 more cycles
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(((8'h3C >> i) & 8'h01) != 0, 16);
        drive_bit(1'b0, 16 + 100);
        check("brk_ferr",  32'(fe_cnt), 32'd1);
        check("brk_state", 32'(dbg_state), 32'(ST_WAIT_HIGH));
        check("brk_empty", 32'(fifo_empty), 32'd1);
        rx = 1'b1;
        idle(10);
        check("brk_idle",  32'(dbg_state), 32'(ST_IDLE));
        check("brk_ferr2", 32'(fe_cnt), 32'd1);

        // clkdiv changed mid-frame has no effect on the frame in flight
        fork
            send_frame(8'h96, 1'b1, 16);
            begin
                idle(30);
                clkdiv = 16'd7;
            end
        join
        idle(4);
        clkdiv = 16'd15;
        check("chg_level", 32'(fifo_level), 32'd1);
        exp_q.push_back(8'h96);
        pop_check("chg_data");

        // 33 back-to-back frames, no reads: fill then overrun
        for (int i = 0; i < 33; i++) begin
            send_frame(8'(i), 1'b1, 16);
            if (i < 32) exp_q.push_back(8'(i));
            if (i == 31) check("full_no_ovr", 32'(ov_cnt), 32'd0);
        end
        idle(4);
        check("full_level", 32'(fifo_level), 32'd32);
        check("full_ovr",   32'(ov_cnt), 32'd1);
        check("full_ferr",  32'(fe_cnt), 32'd1);
        for (int i = 0; i < 32; i++) pop_check($sformatf("full_rd%0d", i));
        check("full_drained", 32'(fifo_empty), 32'd1);

        // Reset during bit 4 of a frame (0xC3), then a clean 0x5A
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0, 16);
        drive_bit(1'b0, 8);
        rst_n = 1'b0;
        rx = 1'b1;
        idle(3);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_empty", 32'(fifo_empty), 32'd1);
        rst_n = 1'b1;
        idle(40);
        check("mid_rst_noflag", 32'(fe_cnt + ov_cnt), 32'd2);
        check("mid_rst_nopush", 32'(fifo_level), 32'd0);
        send_frame(8'h5A, 1'b1, 16);
        idle(4);
        check("mid_rst_level", 32'(fifo_level), 32'd1);
        exp_q.push_back(8'h5A);
        pop_check("mid_rst_data");

        // clkdiv=3, back-to-back 0xFF/0x00, reader pops as soon as data shows
        clkdiv = 16'd3;
        idle(2);
        max_level = 0;
        fork
            begin
                send_frame(8'hFF, 1'b1, 4);
                send_frame(8'h00, 1'b1, 4);
            end
            begin
                repeat (120) begin
                    @(negedge clk);
                    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
                    if (!fifo_empty && !fifo_read) got_q.push_back(fifo_out);
                    fifo_read = !fifo_empty && !fifo_read;
                end
                fifo_read = 1'b0;
            end
        join
        check("fast_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("fast_b0", 32'(got_q[0]), 32'hFF);
            check("fast_b1", 32'(got_q[1]), 32'h00);
        end
        check("fast_maxlvl", 32'(max_level), 32'd1);
        check("fast_ferr",   32'(fe_cnt), 32'd1);
        check("fast_empty",  32'(fifo_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 The module SHALL have parameter SIZE, default 5, giving log2 of the receive FIFO depth (32 entries).
REQ-002 The module SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The module SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The module SHALL have port clkdiv, input, 16, where bit period = clkdiv+1 clk cycles, valid range 3..65535.
REQ-005 The module SHALL have port rx, input, 1, the asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The module SHALL have port fifo_out, output, 8, the oldest received byte.
REQ-007 The module SHALL have port fifo_read, input, 1; a high cycle pops one byte when the FIFO is not empty.
REQ-008 The module SHALL have port fifo_level, output, 6, the number of occupied FIFO entries.
REQ-009 The module SHALL have port fifo_empty, output, 1, high when fifo_level==0.
REQ-010 The module SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-011 The module SHALL have port overrun, output, 1, a one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE: when rxs==0, the FSM SHALL latch clkdiv into div_q, clear baud_ctr and bit_ctr, and go to START.
REQ-015 START: at baud_ctr==div_q>>1, if rxs==0 the FSM SHALL clear baud_ctr and go to DATA; otherwise it SHALL treat the event as a glitch and return to IDLE.
REQ-016 DATA: baud_ctr SHALL count 0..div_q; at baud_ctr==div_q the FSM SHALL shift rxs into shreg bit bit_ctr and increment bit_ctr; after bit 7 it SHALL go to STOP.
REQ-017 STOP: at baud_ctr==div_q, if rxs==1 the byte SHALL be pushed and the FSM SHALL go to IDLE; if the FIFO is full, the byte SHALL be dropped, overrun SHALL pulse, and the FSM SHALL go to IDLE.
REQ-018 STOP with rxs==0 SHALL discard the byte, pulse frame_err, and go to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL stay until rxs==1, then go to IDLE, so a break is not re-detected as a start.
REQ-020 Changes to clkdiv mid-frame SHALL have no effect until the next start detection.
REQ-021 Push SHALL occur on the stop-sample cycle; fifo_empty SHALL fall no more than 2 cycles later.
REQ-022 A simultaneous push and pop SHALL both take effect, leaving fifo_level unchanged when the FIFO is neither empty nor full.
REQ-023 fifo_read while the FIFO is empty SHALL be ignored.
REQ-024 A push while full SHALL leave the FIFO contents unchanged.
REQ-025 The DATA-sample-to-DATA-sample period SHALL be exactly div_q+1 cycles.
REQ-026 A new start bit SHALL be accepted on the cycle after STOP returns to IDLE.

Reset
REQ-027 While rst_n==0 the module SHALL hold: state=IDLE, synchronizer=1, baud_ctr=0, bit_ctr=0, shreg=0, frame_err=0, overrun=0, FIFO cleared, fifo_empty=1, fifo_level=0.
REQ-028 A reset asserted mid-frame SHALL abandon the frame, push no byte, and raise no error pulse.
REQ-029 After rst_n deassertion, the module SHALL receive the first complete frame correctly.

Structure
REQ-030 The state encoding and the framing constants (DATA_BITS=8, SYNC_STAGES=2) SHALL reside in shared package uart_pkg.
REQ-031 Buffering SHALL use one instance of the codebase's axi_fifo (WIDTH=8, SIZE=SIZE) as the only sub-module.
REQ-032 fifo_read SHALL connect to o_tready, and fifo_empty SHALL be ~o_tvalid.
REQ-033 The FSM, the counters and the synchronizer SHALL be local to this module.

Verification
REQ-034 clkdiv=15, rx frame 0xA5 -> fifo_out=0xA5, fifo_level=1, no frame_err or overrun pulse.
REQ-035 clkdiv=15, rx low for 4 cycles, then high -> no push, FSM back in IDLE, fifo_empty=1.
REQ-036 clkdiv=15, frame 0x3C with stop bit=0 -> one frame_err pulse, no push; rx held low for 100 cycles -> no further activity until rx goes high.
REQ-037 SIZE=5, 33 back-to-back frames 0x00..0x20 with no reads -> fifo_level=32, one overrun pulse on the 33rd frame, reads return 0x00..0x1F.
REQ-038 rst_n pulsed low during bit 4 of a frame, then a clean frame 0x5A -> only 0x5A received.
REQ-039 clkdiv=3, back-to-back 0xFF and 0x00, with fifo_read asserted on the push cycle -> both bytes received in order, fifo_level never exceeds 1.
